// File: rtl/phy_rx_deserializer_pkg.sv
// rtl/phy_rx_deserializer_pkg.sv - shared constants and FSM state type for the PHY receive deserializer
package phy_rx_deserializer_pkg;

  // Alignment/idle symbol sent by the transmit path on idle lanes
  localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

  // Consecutive aligned COMs required before declaring lock
  localparam int COM_LOCK_DEF = 4;

  // Receive alignment states; encoding 2'd3 is unused and decodes to SEARCH
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  // True when a recovered byte is the alignment/idle symbol
  function automatic logic is_com(input logic [7:0] b, input logic [7:0] com);
    return b == com;
  endfunction

endpackage

// File: rtl/phy_sat_counter.sv
// rtl/phy_sat_counter.sv - saturating up-counter with synchronous active-high reset
module phy_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // Count increments, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// rtl/phy_rx_deserializer.sv - serial-to-byte receive deserializer with COM alignment; PHY_RX_BYTE_CNT_EN adds a valid-byte counter
module phy_rx_deserializer
  import phy_rx_deserializer_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int         COM_LOCK   = COM_LOCK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_stb,
  output logic        active
`ifdef PHY_RX_BYTE_CNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam logic [3:0] LOCK_N = COM_LOCK[3:0];

  rx_state_t  state, state_nxt;
  // Previous seven bits; the eighth bit of the current byte is data_in itself
  logic [6:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       stb_nxt;
  logic       active_nxt;
  logic [7:0] byte_nxt;

  assign byte_nxt = {sr, data_in};

  // State, shift register, bit/COM counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= byte_nxt[6:0];
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      byte_stb  <= stb_nxt;
      active    <= active_nxt;
    end
  end

  // Alignment hunt, lock qualification and byte emission
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    stb_nxt     = 1'b0;
    active_nxt  = active;
    case (state)
      SEARCH: begin
        // Bit-by-bit hunt: any COM found at an arbitrary offset sets the byte phase
        if (is_com(byte_nxt, COM_SYMBOL)) begin
          bit_cnt_nxt = 3'd0;
          com_cnt_nxt = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (is_com(byte_nxt, COM_SYMBOL)) begin
            com_cnt_nxt = com_cnt + 4'd1;
            if (com_cnt + 4'd1 == LOCK_N) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            // Broken COM train: drop phase and hunt again from the next bit
            com_cnt_nxt = 4'd0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Lock is sticky; only reset leaves this state
        active_nxt  = 1'b1;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_nxt  = byte_nxt;
          valid_nxt = !is_com(byte_nxt, COM_SYMBOL);
          stb_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt   = SEARCH;
        bit_cnt_nxt = 3'd0;
        com_cnt_nxt = 4'd0;
        active_nxt  = 1'b0;
      end
    endcase
  end

`ifdef PHY_RX_BYTE_CNT_EN
  // Count advances on the same edge as the strobe of a valid byte
  phy_sat_counter #(
    .WIDTH (16)
  ) u_byte_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stb_nxt && valid_nxt),
    .count (byte_count)
  );
`endif

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// tb/tb_phy_rx_deserializer.sv - directed self-checking bench for phy_rx_deserializer
module tb_phy_rx_deserializer;

  logic        clk;
  logic        reset;
  logic        data_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        byte_stb;
  logic        active;
`ifdef PHY_RX_BYTE_CNT_EN
  logic [15:0] byte_count;
`endif

  int total_checks;
  int passed_checks;
  int mid_stb;

  phy_rx_deserializer dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
`ifdef PHY_RX_BYTE_CNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    assert (got === exp) passed_checks++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // One bit per edge; returns #1 after the edge that sampled it
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // MSB first; counts strobes seen after the first seven bits
  task automatic send_byte(input logic [7:0] b);
    mid_stb = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0 && byte_stb) mid_stb++;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_strobe(input string tag, input logic [7:0] d, input logic v);
    check({tag, "_mid_stb"}, mid_stb, 0);
    check({tag, "_stb"}, byte_stb, 1'b1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_valid"}, valid_out, v);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset   = 1'b0;
    data_in = 1'b0;
    @(posedge clk);
    #1;

    // 1. Lock at offset 0, then one data byte
    do_reset();
    check("rst_active", active, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_stb", byte_stb, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check("t1_not_locked_3com", active, 1'b0);
    send_byte(8'hBC);
    check("t1_locked", active, 1'b1);
    check("t1_com_not_emitted", byte_stb, 1'b0);
    send_byte(8'hFF);
    check_strobe("t1_ff", 8'hFF, 1'b1);
    check("t1_data_out_hold_pre", data_out, 8'hFF);

    // 4. Idle inside ACTIVE: strobes exactly 8 clk apart
    send_byte(8'hAA);
    check_strobe("t4_aa", 8'hAA, 1'b1);
    send_byte(8'hBC);
    check_strobe("t4_bc", 8'hBC, 1'b0);
    send_byte(8'h55);
    check_strobe("t4_55", 8'h55, 1'b1);
    send_bit(1'b0);
    check("t4_stb_drop", byte_stb, 1'b0);
    check("t4_data_hold", data_out, 8'h55);
    check("t4_valid_hold", valid_out, 1'b1);

    // 5. Mid-byte reset at bit 4 of an ACTIVE byte
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    do_reset();
    check("t5_active", active, 1'b0);
    check("t5_data", data_out, 8'h00);
    check("t5_valid", valid_out, 1'b0);
    check("t5_stb", byte_stb, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check("t5_not_relocked", active, 1'b0);
    send_byte(8'hBC);
    check("t5_relocked", active, 1'b1);
    send_byte(8'hC3);
    check_strobe("t5_c3", 8'hC3, 1'b1);

    // 2. Misaligned start: 101 junk, then COMs
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    check("t2_locked", active, 1'b1);
    check("t2_no_stb_at_lock", byte_stb, 1'b0);
    send_byte(8'h5A);
    check_strobe("t2_5a", 8'h5A, 1'b1);

    // 3. Broken COM train
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h3C);
    check("t3_after_3c", active, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check("t3_3_more_com", active, 1'b0);
    send_byte(8'hBC);
    check("t3_locked", active, 1'b1);
    send_byte(8'h81);
    check_strobe("t3_81", 8'h81, 1'b1);

`ifdef PHY_RX_BYTE_CNT_EN
    // 6. Valid-byte counter and saturation
    do_reset();
    check("t6_cnt_reset", byte_count, 16'h0000);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(k + 1));
      if (k % 4 == 1) send_byte(8'hBC);
    end
    check("t6_cnt_10", byte_count, 16'd10);
    force dut.u_byte_cnt.count = 16'hFFFE;
    #1;
    release dut.u_byte_cnt.count;
    for (int k = 0; k < 3; k++) send_byte(8'h11);
    check("t6_cnt_sat", byte_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
